// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: decode/execute/memory hazard inputs and the stall/flush controls they produce.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [2:0]       id_rs_sel;
    logic             id_rs_used;
    logic [2:0]       id_rt_sel;
    logic             id_rt_used;
    logic             id_reg_write_en;
    logic [2:0]       id_write_reg_sel;
    logic             ex_branch_taken;
    logic             mem_stall;
    logic             insert_NOP;
    logic             stall_FD;
    logic             flush_FD;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
               id_reg_write_en, id_write_reg_sel, ex_branch_taken, mem_stall,
        input  insert_NOP, stall_FD, flush_FD, pipe_freeze, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
               id_reg_write_en, id_write_reg_sel, ex_branch_taken, mem_stall,
        output insert_NOP, stall_FD, flush_FD, pipe_freeze, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: RAW stall, branch flush and memory freeze control for a 5-stage pipeline.
module hazard_stall_ctrl #(
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_ctrl_if.slave hz
);
    // The oldest entry has already written the register file by the time decode reads it.
    localparam int NCMP = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    logic [DEPTH-1:0]      r_sb_v;
    logic [DEPTH-1:0][2:0] r_sb_reg;
    logic                  r_flush_pend;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic                  w_rs_hit;
    logic                  w_rt_hit;
    logic                  w_raw;
    logic                  w_flush;
    logic                  w_stall;
    logic                  w_nop;
    logic                  w_push;

    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        for (int i = 0; i < NCMP; i++) begin
            w_rs_hit = w_rs_hit | (r_sb_v[i] & (r_sb_reg[i] == hz.id_rs_sel));
            w_rt_hit = w_rt_hit | (r_sb_v[i] & (r_sb_reg[i] == hz.id_rt_sel));
        end
    end

    assign w_raw   = hz.id_valid & ((hz.id_rs_used & w_rs_hit) | (hz.id_rt_used & w_rt_hit));
    assign w_flush = ~hz.mem_stall & (hz.ex_branch_taken | r_flush_pend);
    assign w_stall = ~hz.mem_stall & ~w_flush & w_raw;
    assign w_nop   = w_flush | w_stall;
    assign w_push  = hz.id_valid & hz.id_reg_write_en & ~w_nop;

    assign hz.insert_NOP  = w_nop;
    assign hz.stall_FD    = w_stall;
    assign hz.flush_FD    = w_flush;
    assign hz.pipe_freeze = hz.mem_stall;
    assign hz.stall_cnt   = r_stall_cnt;

    // A branch seen while frozen is remembered so it flushes once the pipeline moves again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb_v       <= '0;
            r_sb_reg     <= '0;
            r_flush_pend <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            if (hz.mem_stall) begin
                r_flush_pend <= r_flush_pend | hz.ex_branch_taken;
            end else begin
                r_flush_pend <= 1'b0;
                r_sb_v       <= {r_sb_v[DEPTH-2:0], w_push};
                r_sb_reg     <= {r_sb_reg[DEPTH-2:0], hz.id_write_reg_sel};
            end
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule
